down_counter_timer: RTL and testbench
=====================================

Name: down_counter_timer

Overview:
- Loadable, enable-gated 8-bit down-counter. It counts from a reload value toward 0 and emits a one-cycle underflow pulse when the count wraps past 0.
- It is the opposite direction to the team's StaticCounter, which counts up to a parameter and flags overflow.
- Used for countdown timers (game/round timers, delays) in the project datapath. Supports one-shot and auto-reload modes.

Parameters:
- WIDTH, 8, width of count, load_value and the internal reload register.
- START, 235, reload value after reset; must fit in WIDTH bits.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  decrement qualifier; the counter advances only on cycles with enable=1.
- load  in  1  synchronous load strobe.
- load_value  in  WIDTH  value captured on load; it also becomes the new reload value.
- start  in  1  restarts the count from the reload register when in IDLE or DONE.
- auto_reload  in  1  1 = reload and keep running on underflow; 0 = stop in DONE.
- count  out  WIDTH  current count (registered).
- underflow  out  1  one-cycle registered pulse on expiry.
- busy  out  1  1 while the state is RUN.

Behaviour:
- Reset:
  - reset=0 asynchronously forces state=IDLE, count=START, reload_reg=START, underflow=0, busy=0.
  - Release is synchronous to clk; the first active edge after release evaluates the inputs normally.
- States:
  - IDLE: holds count. start -> RUN with count<=reload_reg. load -> RUN with count<=load_value.
  - RUN: busy=1. On an edge with enable=1:
    - count!=0: count<=count-1.
    - count==0: underflow<=1 for the next cycle. If auto_reload=1, count<=reload_reg and stay in RUN. If auto_reload=0, count stays 0 and state->DONE.
    - enable=0: count holds, underflow<=0.
  - DONE: busy=0, count holds at 0. start -> RUN with count<=reload_reg. load -> RUN with count<=load_value.
- Period: in auto-reload with enable held at 1, underflow pulses every reload_reg+1 cycles. This mirrors the up-counter's upTo+1 period.
- Load:
  - load=1 on any edge, in any state: count<=load_value, reload_reg<=load_value, state->RUN, underflow<=0.
  - load has priority over enable, start and expiry.
  - load with load_value=0 is legal: underflow fires on the next enabled edge.
- start while in RUN is ignored. load and start together: load wins.
- underflow is never asserted for 2 consecutive cycles, except when reload_reg=0 with auto_reload=1 and enable=1 continuously; in that case it pulses every cycle.
- auto_reload is sampled only on the expiry edge. Changing it mid-count has no other effect.
- Arithmetic: unsigned modulo 2^WIDTH. count never decrements below 0; the expiry path replaces the wrap.
- Asserting reset mid-count aborts immediately to the reset values above. A pending underflow is cleared.

Test Plan:
- Reset release with enable=1, no start -> count stays 235, busy=0, underflow=0 (IDLE holds).
- start pulse with auto_reload=1, enable=1 -> count steps 235,234,...,0. underflow is high for exactly 1 cycle after the count==0 edge, then count=235. Next underflow comes exactly 236 cycles later.
- load with load_value=3, auto_reload=0, enable=1 -> count 3,2,1,0. One underflow pulse, then busy=0 and count holds 0. A later start reloads 3.
- enable toggled 1/0 each cycle after load of 5 -> count decrements only on enable=1 edges. Expiry takes 12 cycles, with no underflow while enable=0.
- load of 10 asserted on the same edge where count==0 and enable=1 -> count=10, underflow stays 0, state RUN.
- reset driven low asynchronously mid-count (count=100) -> count=235, busy=0, underflow=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/down_counter_timer.sv
// rtl/down_counter_timer.sv - loadable, enable-gated down-counter timer with underflow pulse
//
// Counts from a reload value toward 0. The edge that finds count==0 while
// running is the expiry edge: it raises a one-cycle underflow pulse and then
// either reloads (auto_reload=1) or parks in DONE with count held at 0.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   enable       in   decrement qualifier while running
//   load         in   synchronous load strobe (highest priority)
//   load_value   in   [WIDTH-1:0] new count and new reload value
//   start        in   restart from reload value when IDLE or DONE
//   auto_reload  in   1 = reload on expiry, 0 = stop in DONE
//   count        out  [WIDTH-1:0] registered count
//   underflow    out  registered one-cycle expiry pulse
//   busy         out  high while running
module down_counter_timer #(
  parameter int WIDTH = 8,
  parameter int START = 235
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             underflow,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] START_VAL = WIDTH'(START);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             underflow_q, underflow_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      count_q     <= START_VAL;
      reload_q    <= START_VAL;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      reload_q    <= reload_d;
      underflow_q <= underflow_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    reload_d    = reload_q;
    // underflow is a pulse: it only survives one cycle unless re-raised
    underflow_d = 1'b0;

    if (load) begin
      // load overrides start, enable and a coinciding expiry
      count_d  = load_value;
      reload_d = load_value;
      state_d  = RUN;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            count_d = reload_q;
            state_d = RUN;
          end
        end
        RUN: begin
          if (enable) begin
            if (count_q != '0) begin
              count_d = count_q - WIDTH'(1);
            end else begin
              // expiry replaces the wrap past zero
              underflow_d = 1'b1;
              if (auto_reload) begin
                count_d = reload_q;
              end else begin
                state_d = DONE;
              end
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign count     = count_q;
  assign underflow = underflow_q;
  assign busy      = (state_q == RUN);

endmodule

// File: tb/tb_down_counter_timer.sv
// tb/tb_down_counter_timer.sv - self-checking bench for down_counter_timer
module tb_down_counter_timer;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       load;
  logic [7:0] load_value;
  logic       start;
  logic       auto_reload;
  logic [7:0] count;
  logic       underflow;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // Reference model: a timer is either active or parked; parked timers just
  // hold whatever count they have, so IDLE and DONE need no distinction here.
  bit m_active;
  int m_count;
  int m_reload;
  bit m_uf;

  down_counter_timer #(.WIDTH(8), .START(235)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .load       (load),
    .load_value (load_value),
    .start      (start),
    .auto_reload(auto_reload),
    .count      (count),
    .underflow  (underflow),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_count  = 235;
    m_reload = 235;
    m_uf     = 1'b0;
  endtask

  task automatic model_edge();
    if (load) begin
      m_count  = int'(load_value);
      m_reload = int'(load_value);
      m_active = 1'b1;
      m_uf     = 1'b0;
    end else if (!m_active) begin
      m_uf = 1'b0;
      if (start) begin
        m_count  = m_reload;
        m_active = 1'b1;
      end
    end else if (!enable) begin
      m_uf = 1'b0;
    end else if (m_count > 0) begin
      m_count = m_count - 1;
      m_uf    = 1'b0;
    end else begin
      m_uf = 1'b1;
      if (auto_reload) m_count = m_reload;
      else m_active = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_count", 32'(count), 32'(m_count));
    chk("model_underflow", 32'(underflow), 32'(m_uf));
    chk("model_busy", 32'(busy), 32'(m_active));
  endtask

  initial begin
    int n;
    bit early_uf;

    reset = 1'b0; enable = 1'b0; load = 1'b0; load_value = 8'd0;
    start = 1'b0; auto_reload = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_count", 32'(count), 32'd235);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_underflow", 32'(underflow), 32'd0);
    reset = 1'b1;

    // IDLE holds even with enable high
    enable = 1'b1;
    repeat (5) step();
    chk("idle_hold_count", 32'(count), 32'd235);
    chk("idle_hold_busy", 32'(busy), 32'd0);

    // auto-reload run from 235: expiry 236 edges after start, then every 236
    auto_reload = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    chk("start_count", 32'(count), 32'd235);
    n = 0;
    do begin step(); n++; end while (!underflow && n < 400);
    chk("first_uf_latency", 32'(n), 32'd236);
    chk("reload_after_uf", 32'(count), 32'd235);
    n = 0;
    do begin step(); n++; end while (!underflow && n < 400);
    chk("uf_period", 32'(n), 32'd236);

    // one-shot load of 3
    auto_reload = 1'b0; load = 1'b1; load_value = 8'd3;
    step();
    load = 1'b0;
    chk("load3_count", 32'(count), 32'd3);
    repeat (4) step();
    chk("oneshot_uf", 32'(underflow), 32'd1);
    chk("oneshot_busy", 32'(busy), 32'd0);
    chk("oneshot_count", 32'(count), 32'd0);
    repeat (2) step();
    chk("done_hold_count", 32'(count), 32'd0);
    chk("done_hold_uf", 32'(underflow), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_count", 32'(count), 32'd3);
    chk("restart_busy", 32'(busy), 32'd1);

    // enable toggling after load of 5: expiry on the 12th cycle
    load = 1'b1; load_value = 8'd5; enable = 1'b0;
    step();
    load = 1'b0;
    early_uf = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      enable = (i % 2 == 0);
      step();
      if (i < 12 && underflow) early_uf = 1'b1;
    end
    chk("toggle_no_early_uf", 32'(early_uf), 32'd0);
    chk("toggle_uf_at_12", 32'(underflow), 32'd1);

    // load coinciding with expiry edge wins
    auto_reload = 1'b1; enable = 1'b1; load = 1'b1; load_value = 8'd2;
    step();
    load = 1'b0;
    repeat (2) step();
    chk("pre_collide_count", 32'(count), 32'd0);
    load = 1'b1; load_value = 8'd10;
    step();
    load = 1'b0;
    chk("collide_count", 32'(count), 32'd10);
    chk("collide_uf", 32'(underflow), 32'd0);
    chk("collide_busy", 32'(busy), 32'd1);

    // reload of 0 in auto mode pulses every cycle
    load = 1'b1; load_value = 8'd0;
    step();
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("zero_reload_uf", 32'(underflow), 32'd1);
    end

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      enable      = ($urandom_range(3) != 0);
      load        = ($urandom_range(15) == 0);
      start       = ($urandom_range(7) == 0);
      auto_reload = 1'($urandom_range(1));
      load_value  = ($urandom_range(1) != 0) ? 8'($urandom_range(7)) : 8'($urandom_range(255));
      step();
    end

    // asynchronous reset mid-count
    load = 1'b1; load_value = 8'd200; start = 1'b0; enable = 1'b1; auto_reload = 1'b1;
    step();
    load = 1'b0;
    n = 0;
    while (count != 8'd100 && n < 300) begin step(); n++; end
    chk("reached_100", 32'(count), 32'd100);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    chk("async_reset_count", 32'(count), 32'd235);
    chk("async_reset_busy", 32'(busy), 32'd0);
    chk("async_reset_uf", 32'(underflow), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
